// File: rtl/cdb_pkg.sv
// Shared types and sizes for the common data bus arbiter.
// Index order of the requesters follows the whichMath encoding (fu_e).
package cdb_pkg;
    localparam int ROBsize    = 32;
    localparam int ROBsizeLog = $clog2(ROBsize + 1);
    localparam int NUM_FU     = 4;
    localparam int NUM_REQ    = NUM_FU;
    localparam int DATA_W     = 65;
    localparam int SRC_W      = $clog2(NUM_REQ);
    localparam int CNT_W      = 32;

    typedef enum logic [SRC_W-1:0] {
        FU_ALU,
        FU_SHIFT,
        FU_MEM,
        FU_BRANCH
    } fu_e;

    typedef struct packed {
        logic [ROBsizeLog-1:0] tag;
        logic [DATA_W-1:0]     data;
    } cdb_entry_t;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request side and CDB broadcast side of the arbiter.
// master = FUs/ROB environment, slave = cdb_arbiter.
interface cdb_arbiter_if;
    import cdb_pkg::*;

    logic [NUM_REQ-1:0]                  req_valid_i;
    logic [NUM_REQ-1:0][ROBsizeLog-1:0]  req_tag_i;
    logic [NUM_REQ-1:0][DATA_W-1:0]      req_data_i;
    logic [NUM_REQ-1:0]                  req_ready_o;
    logic                                cdb_valid_o;
    logic [ROBsizeLog-1:0]               cdb_tag_o;
    logic [DATA_W-1:0]                   cdb_data_o;
    logic [SRC_W-1:0]                    cdb_src_o;
    logic                                cdb_ready_i;
    logic                                err_tag0_o;
    logic [NUM_REQ-1:0][CNT_W-1:0]       perf_grant_cnt_o;

    modport master (
        output req_valid_i, req_tag_i, req_data_i, cdb_ready_i,
        input  req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o,
               err_tag0_o, perf_grant_cnt_o
    );

    modport slave (
        input  req_valid_i, req_tag_i, req_data_i, cdb_ready_i,
        output req_ready_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o,
               err_tag0_o, perf_grant_cnt_o
    );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_gnt
);
    localparam int IW = $clog2(N);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        sum     = '0;
        idx     = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                sum = {1'b0, ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
                if (req[idx] && !any_gnt) begin
                    any_gnt  = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                end
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one FU result per cycle into a broadcast register.
// Optional grant counters enabled by defining CDB_PERF_CNT_EN.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    cdb_arbiter_if.slave  bus
);
    logic [SRC_W-1:0] rr_ptr;
    cdb_entry_t       entry_q;
    cdb_entry_t       req_entry;
    logic             valid_q;
    fu_e              src_q;
    logic             err_q;

    logic             free;
    logic             grant_en;
    logic             any_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [SRC_W-1:0] gnt_idx;

    // A drain and a refill may share a cycle, so the register is free whenever the ROB takes it.
    assign free     = ~valid_q | bus.cdb_ready_i;
    assign grant_en = free & ~flush_i & ~reset_i;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (bus.req_valid_i),
        .ptr     (rr_ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign bus.req_ready_o = gnt;
    assign req_entry.tag   = bus.req_tag_i[gnt_idx];
    assign req_entry.data  = bus.req_data_i[gnt_idx];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr  <= '0;
            valid_q <= 1'b0;
            entry_q <= '0;
            src_q   <= FU_ALU;
            err_q   <= 1'b0;
        end else if (any_gnt) begin
            rr_ptr  <= next_idx(gnt_idx);
            entry_q <= req_entry;
            src_q   <= fu_e'(gnt_idx);
            // Tag 0 names the register file, never a producer: consume it silently.
            valid_q <= (req_entry.tag != '0);
            if (req_entry.tag == '0) begin
                err_q <= 1'b1;
            end
        end else if (flush_i | bus.cdb_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.cdb_valid_o = valid_q;
    assign bus.cdb_tag_o   = entry_q.tag;
    assign bus.cdb_data_o  = entry_q.data;
    assign bus.cdb_src_o   = src_q;
    assign bus.err_tag0_o  = err_q;

`ifdef CDB_PERF_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            for (int n = 0; n < NUM_REQ; n++) begin
                if (gnt[n] && bus.req_valid_i[n] && (cnt_q[n] != '1)) begin
                    cnt_q[n] <= cnt_q[n] + 1'b1;
                end
            end
        end
    end

    assign bus.perf_grant_cnt_o = cnt_q;
`else
    assign bus.perf_grant_cnt_o = '0;
`endif
endmodule
